// File: rtl/pitch_mix_out.sv
`default_nettype none
// ============================================================================
// Module      : pitch_mix_out
// Description : Dry/wet output mixer for the pitch shifter. The wet coefficient
//               ramps on each accepted sample so that effect changes are
//               click-free.
// Revision    : 1.0 - initial release
// ============================================================================
module pitch_mix_out #(
    parameter int DATA_W    = 32,
    parameter int RAMP_STEP = 1
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dry_in,
    input  logic [DATA_W-1:0] wet_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              effect_en,
    input  logic [8:0]        mix_target,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ramping
);

    localparam int c_PROD_W = DATA_W + 10;
    localparam int c_SUM_W  = c_PROD_W + 1;
    localparam logic [8:0] c_STEP = 9'(RAMP_STEP);
    localparam logic [8:0] c_FULL = 9'd256;
    localparam logic signed [c_SUM_W-1:0] c_MAX = c_SUM_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [c_SUM_W-1:0] c_MIN = ~c_MAX;

    typedef enum logic [1:0] {
        ST_BYPASS = 2'd0,
        ST_MIX    = 2'd1,
        ST_RAMP   = 2'd2
    } state_t;

    state_t                      r_state;
    logic [8:0]                  r_m;
    logic [8:0]                  w_m_next;
    logic [8:0]                  w_tgt;
    logic                        w_adv;
    logic                        w_accept;
    logic                        r_s1_valid;
    logic signed [c_PROD_W-1:0]  r_p_d;
    logic signed [c_PROD_W-1:0]  r_p_w;
    logic signed [c_PROD_W-1:0]  w_prod_d;
    logic signed [c_PROD_W-1:0]  w_prod_w;
    logic signed [9:0]           w_coef_w;
    logic signed [9:0]           w_coef_d;
    logic signed [c_SUM_W-1:0]   w_sum;
    logic signed [c_SUM_W-1:0]   w_shift;
    logic [DATA_W-1:0]           w_sat;
    logic [DATA_W-1:0]           r_data_out;
    logic                        r_out_valid;

    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = w_adv;
    assign w_accept = in_valid & w_adv;

    assign w_tgt = effect_en ? ((mix_target > c_FULL) ? c_FULL : mix_target) : 9'd0;

    // The ramp never overshoots tgt, so m always stays inside 0..256.
    always_comb begin
        w_m_next = r_m;
        if (w_accept) begin
            if (w_tgt > r_m) begin
                if ((w_tgt - r_m) <= c_STEP) w_m_next = w_tgt;
                else                         w_m_next = r_m + c_STEP;
            end else if (w_tgt < r_m) begin
                if ((r_m - w_tgt) <= c_STEP) w_m_next = w_tgt;
                else                         w_m_next = r_m - c_STEP;
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_m     <= 9'd0;
            r_state <= ST_BYPASS;
        end else begin
            r_m <= w_m_next;
            if (w_m_next != w_tgt)  r_state <= ST_RAMP;
            else if (w_tgt == 9'd0) r_state <= ST_BYPASS;
            else                    r_state <= ST_MIX;
        end
    end

    assign ramping = (r_state == ST_RAMP);

    assign w_coef_w = signed'({1'b0, r_m});
    assign w_coef_d = 10'sd256 - w_coef_w;
    assign w_prod_d = c_PROD_W'(signed'(dry_in)) * c_PROD_W'(w_coef_d);
    assign w_prod_w = c_PROD_W'(signed'(wet_in)) * c_PROD_W'(w_coef_w);

    assign w_sum   = c_SUM_W'(r_p_d) + c_SUM_W'(r_p_w) + c_SUM_W'(128);
    assign w_shift = w_sum >>> 8;

    always_comb begin
        if (w_shift > c_MAX)      w_sat = c_MAX[DATA_W-1:0];
        else if (w_shift < c_MIN) w_sat = c_MIN[DATA_W-1:0];
        else                      w_sat = w_shift[DATA_W-1:0];
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_p_d       <= '0;
            r_p_w       <= '0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_p_d <= w_prod_d;
                r_p_w <= w_prod_w;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) r_data_out <= w_sat;
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_pitch_mix_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_pitch_mix_out
// Description : Directed vector bench for the dry/wet output mixer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pitch_mix_out;

    logic               Clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [31:0] dry_in = '0;
    logic signed [31:0] wet_in = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               effect_en = 1'b0;
    logic [8:0]         mix_target = '0;
    logic [31:0]        data_out;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               ramping;

    int total = 0;
    int bad   = 0;
    int m_model = 0;
    logic signed [31:0] exp_cur = '0;
    logic signed [31:0] exp_q[$];
    logic               hold_pend = 1'b0;
    logic [31:0]        hold_val = '0;

    typedef struct {
        logic               en;
        logic [8:0]         tgt;
        logic signed [31:0] dry;
        logic signed [31:0] wet;
        logic signed [31:0] exp;
        logic               ramp;
    } vec_t;
    vec_t vt[8];

    pitch_mix_out #(.DATA_W(32), .RAMP_STEP(1)) dut (
        .Clk(Clk), .reset(reset), .dry_in(dry_in), .wet_in(wet_in),
        .in_valid(in_valid), .in_ready(in_ready), .effect_en(effect_en),
        .mix_target(mix_target), .data_out(data_out), .out_valid(out_valid),
        .out_ready(out_ready), .ramping(ramping)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h) at %0t",
                     name, $signed(act), act, $signed(req), req, $time);
        end
    endtask

    // Scoreboard: record expected value at accept, compare at output transfer.
    always @(negedge Clk) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_data", data_out, hold_val);
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = data_out;
            if (in_valid && in_ready) exp_q.push_back(exp_cur);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out: got 0x%h want no output", data_out);
                end else begin
                    check("stream_data", data_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic signed [31:0] d, input logic signed [31:0] w,
                        input logic signed [31:0] e);
        logic acc;
        dry_in   = d;
        wet_in   = w;
        exp_cur  = e;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge Clk);
            acc = in_ready;
            @(posedge Clk);
            #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles want accept");
        end
    endtask

    task automatic ramp(input int n, input int tgt);
        for (int i = 0; i < n; i++) begin
            send(32'sd0, 32'sd25600, 32'(100 * m_model));
            if (m_model < tgt)      m_model++;
            else if (m_model > tgt) m_model--;
            check("ramp_flag", 32'(ramping), 32'(m_model != tgt));
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge Clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vt[0] = '{1'b0, 9'd0,   32'sd1000, -32'sd5000,  32'sd1000,   1'b0};
        vt[1] = '{1'b1, 9'd256, 32'sd0,     32'sd25600, 32'sd0,      1'b1};
        vt[2] = '{1'b1, 9'd256, 32'sd0,     32'sd25600, 32'sd100,    1'b1};
        vt[3] = '{1'b1, 9'd256, 32'sd1000, -32'sd5000,  32'sd953,    1'b1};
        vt[4] = '{1'b0, 9'd256, 32'sd256,   32'sd0,     32'sd253,    1'b1};
        vt[5] = '{1'b0, 9'd256, -32'sd1000, 32'sd0,    -32'sd992,    1'b1};
        vt[6] = '{1'b0, 9'd256, 32'sd7,     32'sd9,     32'sd7,      1'b0};
        vt[7] = '{1'b0, 9'd0,  -32'sd123456, 32'sd0,   -32'sd123456, 1'b0};

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_ramping", 32'(ramping), 32'd0);
        reset = 1'b0;
        @(posedge Clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single-sample vectors: latency, rounding, short ramp up and down
        for (int i = 0; i < 8; i++) begin
            effect_en  = vt[i].en;
            mix_target = vt[i].tgt;
            send(vt[i].dry, vt[i].wet, vt[i].exp);
            in_valid = 1'b0;
            check("lat_s1_quiet", 32'(out_valid), 32'd0);
            check("vec_ramping", 32'(ramping), 32'(vt[i].ramp));
            @(posedge Clk);
            #1;
            check("lat_valid", 32'(out_valid), 32'd1);
            check("vec_data", data_out, vt[i].exp);
        end
        drain();
        m_model = 0;

        // Full ramp to all-wet (300 clamps to 256) with a 5-cycle stall mid-stream
        effect_en  = 1'b1;
        mix_target = 9'd300;
        fork
            ramp(257, 256);
            begin
                repeat (60) @(posedge Clk);
                #1;
                out_ready = 1'b0;
                @(negedge Clk);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                repeat (5) @(posedge Clk);
                #1;
                out_ready = 1'b1;
            end
        join

        // Redirect down to 100, then disable effect: ramp back to dry
        mix_target = 9'd100;
        ramp(156, 100);
        effect_en = 1'b0;
        ramp(100, 0);
        send(-32'sd777, 32'sd5555, -32'sd777);
        check("bypass_ramping", 32'(ramping), 32'd0);
        drain();

        // Extremes at m=128
        effect_en  = 1'b1;
        mix_target = 9'd128;
        ramp(128, 128);
        send(32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF);
        send(32'sh80000000, 32'sh80000000, 32'sh80000000);
        send(32'sd1000, -32'sd5000, -32'sd2000);
        drain();

        // Async reset mid-ramp with samples in flight
        mix_target = 9'd256;
        ramp(10, 256);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_data_out", data_out, 32'd0);
        check("arst_ramping", 32'(ramping), 32'd0);
        exp_q.delete();
        m_model = 0;
        @(negedge Clk);
        #3;
        reset = 1'b0;
        @(posedge Clk);
        #1;
        check("arst_no_stale", 32'(out_valid), 32'd0);
        send(32'sd4321, -32'sd99, 32'sd4321);
        check("arst_ramp_restart", 32'(ramping), 32'd1);
        in_valid = 1'b0;
        @(posedge Clk);
        #1;
        check("arst_first_valid", 32'(out_valid), 32'd1);
        check("arst_first_dry", data_out, 32'sd4321);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
